// File: rtl/switch_debouncer_de2.sv
// Synchronises and debounces the DE2 slide switches feeding the full adder
// operands, with per-bit edge pulses and a startup-valid flag.
module switch_debouncer_de2 #(
  parameter int WIDTH           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW_IN,
  output logic [WIDTH-1:0] SW_OUT,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_VALID
);

  localparam int CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int START_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int START_W      = $clog2(START_CYCLES + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_CYCLES - 1);
  localparam logic [START_W-1:0] START_ONE  = START_W'(1);

  localparam logic [0:0] STABLE  = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [0:0]       state      [WIDTH];
  logic [0:0]       state_next [WIDTH];
  logic [CNT_W-1:0] cnt        [WIDTH];
  logic [CNT_W-1:0] cnt_next   [WIDTH];
  logic [WIDTH-1:0] done;
  logic [START_W-1:0] start_cnt;

  assign s = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_chain[k] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_chain[0] <= SW_IN;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_chain[k] <= sync_chain[k-1];
      end
    end
  end

  // done[i] marks the edge that completes the required mismatch run;
  // with DEBOUNCE_CYCLES=1 that is already the first mismatch seen in STABLE.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      done[i]       = 1'b0;
      case (state[i])
        STABLE: begin
          if (s[i] != SW_OUT[i]) begin
            if (cnt[i] == CNT_LAST) begin
              done[i] = 1'b1;
            end else begin
              state_next[i] = PENDING;
              cnt_next[i]   = CNT_ONE;
            end
          end else begin
            cnt_next[i] = {CNT_W{1'b0}};
          end
        end
        PENDING: begin
          if (s[i] == SW_OUT[i]) begin
            state_next[i] = STABLE;
            cnt_next[i]   = {CNT_W{1'b0}};
          end else if (cnt[i] == CNT_LAST) begin
            done[i]       = 1'b1;
            state_next[i] = STABLE;
            cnt_next[i]   = {CNT_W{1'b0}};
          end else begin
            cnt_next[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_next[i] = STABLE;
          cnt_next[i]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= {CNT_W{1'b0}};
      end
      SW_OUT  <= {WIDTH{1'b0}};
      SW_RISE <= {WIDTH{1'b0}};
      SW_FALL <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
      SW_OUT  <= SW_OUT ^ done;
      // Pulses are gated by the flag as it stood before this edge.
      SW_RISE <= done & s & {WIDTH{SW_VALID}};
      SW_FALL <= done & ~s & {WIDTH{SW_VALID}};
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      start_cnt <= {START_W{1'b0}};
      SW_VALID  <= 1'b0;
    end else if (!SW_VALID) begin
      if (start_cnt == START_LAST) begin
        SW_VALID <= 1'b1;
      end else begin
        start_cnt <= start_cnt + START_ONE;
      end
    end else begin
      SW_VALID <= 1'b1;
    end
  end

endmodule
